ps2_kbd_rx: RTL

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_pkg.sv | 9 +
 rtl/ps2_kbd_rx_if.sv | 12 +
 rtl/ps2_rx_fifo.sv | 38 +++
 rtl/ps2_kbd_rx.sv | 97 +++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver types, default sizing and the odd-parity check.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int TIMEOUT_CYCLES_DEF = 50000;
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: CPU-side scancode/status bus of the PS/2 keyboard receiver.
interface ps2_kbd_rx_if;
  logic       rd;
  logic       clr;
  logic [7:0] keyboard_in;
  logic       ready;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;
  modport master (output rd, clr, input keyboard_in, ready, overflow, parity_err, frame_err);
  modport slave (input rd, clr, output keyboard_in, ready, overflow, parity_err, frame_err);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous scancode FIFO; push while full is accepted only alongside a pop.
module ps2_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic do_pop, do_push;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = empty ? 8'h00 : mem[rptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with scancode FIFO and sticky error flags.
module ps2_kbd_rx import ps2_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst,
  input logic         ps2_clk,
  input logic         ps2_data,
  ps2_kbd_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [2:0] clk_s;
  logic [1:0] dat_s;
  logic fall, bit_in, timeout, push, full, empty, set_ovf, set_par, set_frm, par_ok;
  state_t state, state_n;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic [TW-1:0] to_cnt;
  assign fall = clk_s[2] & ~clk_s[1];
  assign bit_in = dat_s[1];
  assign timeout = state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign bus.ready = ~empty;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s <= 3'b111;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[1:0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
    end
  end
  always_comb begin
    state_n = state;
    push = 1'b0;
    set_ovf = 1'b0;
    set_par = 1'b0;
    set_frm = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    state_n = bit_in ? IDLE : DATA;
        DATA:    state_n = bitcnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          set_frm = ~bit_in;
          set_par = bit_in & ~par_ok;
          push = bit_in & par_ok & (~full | bus.rd);
          set_ovf = bit_in & par_ok & full & ~bus.rd;
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n = IDLE;
      set_frm = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bitcnt <= '0;
      shreg <= '0;
      par_ok <= 1'b0;
      to_cnt <= '0;
      bus.overflow <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state <= state_n;
      to_cnt <= (state == IDLE || fall) ? '0 : to_cnt + TW'(1);
      if (fall && state == IDLE && !bit_in) begin
        bitcnt <= '0;
        shreg <= '0;
      end
      if (fall && state == DATA) begin
        shreg[bitcnt] <= bit_in;
        bitcnt <= bitcnt + 3'd1;
      end
      if (fall && state == PARITY) par_ok <= odd_parity_ok(shreg, bit_in);
      if (timeout && !fall) shreg <= '0;
      // a flag set in the same cycle as clr stays set
      bus.overflow <= set_ovf | (bus.overflow & ~bus.clr);
      bus.parity_err <= set_par | (bus.parity_err & ~bus.clr);
      bus.frame_err <= set_frm | (bus.frame_err & ~bus.clr);
    end
  end
  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (bus.rd),
    .din  (shreg),
    .head (bus.keyboard_in),
    .empty(empty),
    .full (full)
  );
endmodule
